// File: rtl/dac8812_pkg.sv
// Shared types and constants for the DAC8812 serial receive model.
package dac8812_pkg;

  localparam int unsigned DEFAULT_BITS = 18;

  typedef enum logic [1:0] {
    ADDR_NOP = 2'b00,
    ADDR_A   = 2'b01,
    ADDR_B   = 2'b10,
    ADDR_AB  = 2'b11
  } addr_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/dac8812_spi_rx_sync_edge.sv
// Pin synchronizer: SYNC-flop chain plus a history flop; edges come from the
// last chain stage against the history flop.
module sync_edge #(
  parameter int unsigned SYNC      = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC-1:0] chain;
  logic            hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {SYNC{RESET_VAL}};
      hist  <= RESET_VAL;
    end else begin
      chain <= {chain[SYNC-2:0], din};
      hist  <= chain[SYNC-1];
    end
  end

  assign level = chain[SYNC-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/dac8812_spi_rx.sv
// DAC8812 serial receiver: deserialises 18-bit frames, decodes the address into
// the channel input registers and transfers them to the DAC registers on LDAC.
module dac8812_spi_rx
  import dac8812_pkg::*;
#(
  parameter int unsigned BITS = DEFAULT_BITS,
  parameter int unsigned SYNC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sck,
  input  logic            sdi,
  input  logic            cs_n,
  input  logic            ldac_n,
  output logic [BITS-1:0] word,
  output logic            word_valid,
  output logic            frame_err,
  output logic [BITS-3:0] in_a,
  output logic [BITS-3:0] in_b,
  output logic [BITS-3:0] dac_a,
  output logic [BITS-3:0] dac_b,
  output logic            dac_update
);

  localparam int unsigned CW = $clog2(BITS + 2);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic ldac_lvl, ldac_rise, ldac_fall;
  logic unused_sync;

  sync_edge #(.SYNC(SYNC), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .din(sck),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  sync_edge #(.SYNC(SYNC), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge #(.SYNC(SYNC), .RESET_VAL(1'b1)) u_sync_ldac (
    .clk(clk), .rst(rst), .din(ldac_n),
    .level(ldac_lvl), .rise(ldac_rise), .fall(ldac_fall)
  );

  assign unused_sync = ^{sck_lvl, sck_fall, cs_lvl, ldac_lvl, ldac_rise};

  // sdi gets the same depth as sck so the sampled bit lines up with the rise
  logic [SYNC-1:0] sdi_chain;
  logic            sdi_s;

  always_ff @(posedge clk) begin
    if (rst) sdi_chain <= '0;
    else     sdi_chain <= {sdi_chain[SYNC-2:0], sdi};
  end

  assign sdi_s = sdi_chain[SYNC-1];

  state_e state, state_nxt;
  logic   start, shift_en, close;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = SHIFT;
      SHIFT:   if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start    = 1'b0;
    shift_en = 1'b0;
    close    = 1'b0;
    case (state)
      IDLE:  start = cs_fall;
      SHIFT: begin
        close    = cs_rise;
        shift_en = sck_rise & ~cs_rise;
      end
      default: ;
    endcase
  end

  logic [CW-1:0]   cnt;
  logic [BITS-1:0] shifter;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      cnt     <= '0;
      shifter <= '0;
    end else if (shift_en) begin
      shifter <= {shifter[BITS-2:0], sdi_s};
      if (cnt != CW'(BITS + 1)) cnt <= cnt + 1'b1;
    end
  end

  logic            good;
  addr_e           addr;
  logic [BITS-3:0] in_a_nxt, in_b_nxt;

  // next input-register values also feed the DAC registers, giving write-through
  // when a good frame closes in the same cycle as an LDAC fall
  always_comb begin
    good     = close && (cnt == CW'(BITS));
    addr     = addr_e'(shifter[BITS-1 -: 2]);
    in_a_nxt = in_a;
    in_b_nxt = in_b;
    if (good && (addr == ADDR_A || addr == ADDR_AB)) in_a_nxt = shifter[BITS-3:0];
    if (good && (addr == ADDR_B || addr == ADDR_AB)) in_b_nxt = shifter[BITS-3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word       <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      in_a       <= '0;
      in_b       <= '0;
      dac_a      <= '0;
      dac_b      <= '0;
      dac_update <= 1'b0;
    end else begin
      word_valid <= good;
      frame_err  <= close & ~good;
      if (good) word <= shifter;
      in_a       <= in_a_nxt;
      in_b       <= in_b_nxt;
      dac_update <= ldac_fall;
      if (ldac_fall) begin
        dac_a <= in_a_nxt;
        dac_b <= in_b_nxt;
      end
    end
  end

endmodule

// File: tb/tb_dac8812_spi_rx.sv
// Bench for dac8812_spi_rx: a pin-level frame driver feeds a scoreboard of
// expected frame results and DAC transfers, checked as the DUT pulses.
module tb_dac8812_spi_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        sdi = 1'b0;
  logic        cs_n = 1'b1;
  logic        ldac_n = 1'b1;
  logic [17:0] word;
  logic        word_valid, frame_err, dac_update;
  logic [15:0] in_a, in_b, dac_a, dac_b;

  dac8812_spi_rx #(.BITS(18), .SYNC(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .sdi(sdi), .cs_n(cs_n), .ldac_n(ldac_n),
    .word(word), .word_valid(word_valid), .frame_err(frame_err),
    .in_a(in_a), .in_b(in_b), .dac_a(dac_a), .dac_b(dac_b),
    .dac_update(dac_update)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [17:0] w;
    logic [15:0] a;
    logic [15:0] b;
    logic        coinc;
  } ev_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
  } dac_t;

  ev_t  evq[$];
  dac_t dq[$];

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  logic [17:0] m_word = '0;
  logic [15:0] m_a = '0, m_b = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] w, input int nbits, input int hb);
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = w[i];
      sck = 1'b0;
      cyc(hb);
      sck = 1'b1;
      cyc(hb);
    end
    sck = 1'b0;
    cyc(hb);
  endtask

  task automatic model_frame(input logic [31:0] w, input int nbits, input logic coinc);
    ev_t e;
    if (nbits == 18) begin
      m_word = w[17:0];
      if (w[16]) m_a = w[15:0];
      if (w[17]) m_b = w[15:0];
    end
    e.err = (nbits != 18);
    e.w = m_word;
    e.a = m_a;
    e.b = m_b;
    e.coinc = coinc;
    evq.push_back(e);
  endtask

  task automatic push_dac();
    dac_t d;
    d.a = m_a;
    d.b = m_b;
    dq.push_back(d);
  endtask

  // with_ldac drops ldac_n on the same clock as cs_n rises
  task automatic send_frame(input logic [31:0] w, input int nbits, input int hb,
                            input logic with_ldac);
    cs_n = 1'b0;
    cyc(hb);
    send_bits(w, nbits, hb);
    model_frame(w, nbits, with_ldac);
    if (with_ldac) begin
      push_dac();
      ldac_n = 1'b0;
    end
    cs_n = 1'b1;
    cyc(hb + 1);
    ldac_n = 1'b1;
    cyc(2);
  endtask

  task automatic pulse_ldac(input int hb);
    push_dac();
    ldac_n = 1'b0;
    cyc(hb);
    ldac_n = 1'b1;
    cyc(hb + 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((evq.size() != 0 || dq.size() != 0) && n < 100) begin
      cyc(1);
      n++;
    end
    check("drain", evq.size() + dq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (word_valid || frame_err) begin
        if (evq.size() == 0) begin
          check("unexpected_frame_pulse", {word_valid, frame_err}, 2'b00);
        end else begin
          ev_t e;
          e = evq.pop_front();
          check("word_valid", word_valid, !e.err);
          check("frame_err", frame_err, e.err);
          check("word", word, e.w);
          check("in_a", in_a, e.a);
          check("in_b", in_b, e.b);
          check("coincident_update", dac_update, e.coinc);
        end
      end
      if (dac_update) begin
        if (dq.size() == 0) begin
          check("unexpected_dac_update", dac_update, 1'b0);
        end else begin
          dac_t d;
          d = dq.pop_front();
          check("dac_a", dac_a, d.a);
          check("dac_b", dac_b, d.b);
        end
      end
    end
  end

  initial begin
    logic [31:0] r;
    cyc(3);
    rst = 1'b0;
    cyc(4);
    check("rst_word", word, 0);
    check("rst_pulses", {word_valid, frame_err, dac_update}, 0);
    check("rst_in", {in_a, in_b}, 0);
    check("rst_dac", {dac_a, dac_b}, 0);

    send_frame(32'h1ABCD, 18, 2, 1'b0);
    pulse_ldac(2);
    send_frame(32'h31234, 18, 2, 1'b0);
    send_frame(32'h0FFFF, 18, 1, 1'b0);
    send_frame(32'h15555, 17, 2, 1'b0);
    send_frame(32'h6AAAA, 19, 2, 1'b0);
    send_frame(32'h0, 0, 2, 1'b0);
    pulse_ldac(1);
    send_frame(32'h15A5A, 18, 2, 1'b1);
    drain();
    check("writethrough_dac_a", dac_a, 16'h5A5A);

    // abort a frame with reset after 9 bits, then a clean frame
    cs_n = 1'b0;
    cyc(2);
    send_bits(32'h3FFFF, 9, 2);
    rst = 1'b1;
    cs_n = 1'b1;
    cyc(3);
    rst = 1'b0;
    m_word = '0;
    m_a = '0;
    m_b = '0;
    cyc(4);
    check("rst_mid_word", word, 0);
    check("rst_mid_in", {in_a, in_b}, 0);
    send_frame(32'h20F0F, 18, 2, 1'b0);
    drain();
    check("rst_mid_in_b", in_b, 16'h0F0F);

    for (int hbi = 0; hbi < 2; hbi++) begin
      for (int k = 0; k < 200; k++) begin
        r = $urandom;
        send_frame({14'd0, r[17:0]}, 18, (hbi == 0) ? 1 : 4, 1'b0);
        pulse_ldac((hbi == 0) ? 1 : 4);
      end
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
